// File: rtl/mem_arbiter_pkg.sv
// Shared widths, addresses and FSM encodings for the memory arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  localparam int MemAddr   = 16;  // address bus width
  localparam int MemValue  = 16;  // data bus width
  localparam int ActBit    = 2;   // operation token width
  localparam int QueueSize = 4;   // controller receive-queue pointer width
  localparam int WaitCnt   = 16;  // watchdog counter width

  // Memory-mapped UART: data register and locally served status register.
  localparam logic [MemAddr-1:0] UartAddr       = 16'hBF00;
  localparam logic [MemAddr-1:0] UART_STAT_ADDR = 16'hBF01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/op_watchdog.sv
// Wait-cycle counter with timeout compare for one outstanding controller operation.
// Latency: expired is combinational on the cycle the count would reach TIMEOUT.
// Backpressure: none; counts while run is high, zeroed by clear.
//
// Ports: clk, rst (sync, active-high); run = count this cycle; clear = zero
// the counter; expired = this run cycle is the TIMEOUT-th one.
module op_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter logic [WaitCnt-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam logic [WaitCnt-1:0] Last = TIMEOUT - WaitCnt'(1);

  logic [WaitCnt-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + WaitCnt'(1);
    end
  end

  // count holds the number of earlier run cycles, so this run cycle makes TIMEOUT.
  assign expired = run && (count == Last);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU fetch and data requests onto a single token-tagged RAM/UART controller port.
// Latency: accept -> valid 3 cycles minimum (IDLE, ISSUE, WAIT w/ done, DONE); status reads 1 cycle.
// Backpressure: stall held while an accepted op is open; requests held by requester until valid.
//
// Ports: clk/rst (sync active-high); if_req/if_addr -> if_inst/if_valid (fetch);
// dm_rd/dm_wr/dm_addr/dm_wdata -> dm_rdata/dm_valid (data); stall to pipeline;
// need_to_work/mem_rd/mem_wr/mem_addr/mem_value/mem_act command the controller,
// uart_work_done/result answer it; front/tail are controller queue pointers;
// timeout_err is a sticky flag for abandoned ops.
module mem_arbiter
  import mem_arbiter_pkg::MemAddr, mem_arbiter_pkg::MemValue, mem_arbiter_pkg::ActBit,
         mem_arbiter_pkg::QueueSize, mem_arbiter_pkg::state_t, mem_arbiter_pkg::ST_IDLE,
         mem_arbiter_pkg::ST_ISSUE, mem_arbiter_pkg::ST_WAIT, mem_arbiter_pkg::ST_DONE;
#(
  parameter logic [15:0] TIMEOUT        = 16'hFFFF,
  parameter logic [15:0] UART_STAT_ADDR = mem_arbiter_pkg::UART_STAT_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [MemAddr-1:0]   if_addr,
  output logic [MemValue-1:0]  if_inst,
  output logic                 if_valid,
  input  logic                 dm_rd,
  input  logic                 dm_wr,
  input  logic [MemAddr-1:0]   dm_addr,
  input  logic [MemValue-1:0]  dm_wdata,
  output logic [MemValue-1:0]  dm_rdata,
  output logic                 dm_valid,
  output logic                 stall,
  output logic                 need_to_work,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [MemAddr-1:0]   mem_addr,
  output logic [MemValue-1:0]  mem_value,
  output logic [ActBit-1:0]    mem_act,
  input  logic                 uart_work_done,
  input  logic [MemValue-1:0]  result,
  input  logic [QueueSize-1:0] front,
  input  logic [QueueSize-1:0] tail,
  output logic                 timeout_err
);

  state_t state;

  // Which requester owns the open op, and whether it is a store.
  logic lat_data;
  logic lat_wr;

  logic dm_req;
  logic stat_hit;
  logic wd_run;
  logic wd_clear;
  logic wd_expired;
  logic [MemValue-1:0] done_word;

  assign dm_req   = dm_rd || dm_wr;
  // rd+wr together is a store, so only a pure read may hit the status register.
  assign stat_hit = dm_rd && !dm_wr && (dm_addr == UART_STAT_ADDR);

  // Completion is only sampled in WAIT; a done already high in ISSUE is ignored.
  assign wd_run   = (state == ST_WAIT) && !uart_work_done;
  assign wd_clear = (state == ST_DONE);

  // On timeout the requester gets zero instead of stale controller data.
  assign done_word = uart_work_done ? result : '0;

  assign stall = ((state == ST_IDLE) && (dm_req || if_req)) ||
                 (state == ST_ISSUE) || (state == ST_WAIT);

  op_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .run     (wd_run),
    .clear   (wd_clear),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      lat_data     <= 1'b0;
      lat_wr       <= 1'b0;
      mem_act      <= '0;
      need_to_work <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_value    <= '0;
      if_inst      <= '0;
      if_valid     <= 1'b0;
      dm_rdata     <= '0;
      dm_valid     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (stat_hit) begin
            // Served locally; DONE gives the requester one cycle to drop the request.
            dm_rdata <= {{(MemValue-2){1'b0}}, (front != tail), 1'b1};
            dm_valid <= 1'b1;
            state    <= ST_DONE;
          end else if (dm_req) begin
            lat_data     <= 1'b1;
            lat_wr       <= dm_wr;
            mem_act      <= mem_act + ActBit'(1);
            need_to_work <= 1'b1;
            mem_rd       <= !dm_wr;
            mem_wr       <= dm_wr;
            mem_addr     <= dm_addr;
            mem_value    <= dm_wdata;
            state        <= ST_ISSUE;
          end else if (if_req) begin
            lat_data     <= 1'b0;
            lat_wr       <= 1'b0;
            mem_act      <= mem_act + ActBit'(1);
            need_to_work <= 1'b1;
            mem_rd       <= 1'b1;
            mem_wr       <= 1'b0;
            mem_addr     <= if_addr;
            mem_value    <= '0;
            state        <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (uart_work_done || wd_expired) begin
            if (wd_expired) begin
              timeout_err <= 1'b1;
            end
            need_to_work <= 1'b0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            if (lat_data) begin
              dm_valid <= 1'b1;
              // A store completes without disturbing the last load result.
              if (!lat_wr) begin
                dm_rdata <= done_word;
              end
            end else begin
              if_valid <= 1'b1;
              if_inst  <= done_word;
            end
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single ops plus hand sequences.
// Latency: n/a.
// Backpressure: bench requester holds each request until its valid pulse.
module tb_mem_arbiter;

  localparam logic [15:0] TO   = 16'd8;
  localparam logic [15:0] STAT = 16'hBF01;

  logic        clk, rst;
  logic        if_req, if_valid;
  logic [15:0] if_addr, if_inst;
  logic        dm_rd, dm_wr, dm_valid, stall;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        need_to_work, mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_value;
  logic [1:0]  mem_act;
  logic        uart_work_done, timeout_err;
  logic [15:0] result;
  logic [3:0]  front, tail;

  typedef struct {
    bit          fetch;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [3:0]  front;
    logic [3:0]  tail;
    int          delay;     // WAIT cycles without done; negative = never answer
    logic [15:0] res;
    logic [15:0] exp_data;
    bit          exp_terr;
  } vec_t;

  typedef struct {
    bit          fetch;
    logic [15:0] data;
    logic [1:0]  act;
    bit          terr;
  } sb_t;

  sb_t         sb[$];
  vec_t        tbl[9];
  int          tests = 0;
  int          fails = 0;
  int          vcount = 0;
  int          resp_delay = -1;
  logic [15:0] resp_result = '0;
  bit          spur_issue = 0;
  logic [1:0]  act_model = '0;

  mem_arbiter #(
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_inst        (if_inst),
    .if_valid       (if_valid),
    .dm_rd          (dm_rd),
    .dm_wr          (dm_wr),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_rdata       (dm_rdata),
    .dm_valid       (dm_valid),
    .stall          (stall),
    .need_to_work   (need_to_work),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_value      (mem_value),
    .mem_act        (mem_act),
    .uart_work_done (uart_work_done),
    .result         (result),
    .front          (front),
    .tail           (tail),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Controller model: answers resp_delay WAIT cycles after ISSUE; optionally
  // raises a bogus done carrying DEAD during the ISSUE cycle.
  initial begin
    int cnt;
    cnt = 0;
    uart_work_done = 1'b0;
    result = '0;
    forever begin
      @(negedge clk);
      if (need_to_work) cnt++;
      else cnt = 0;
      uart_work_done = 1'b0;
      result = resp_result;
      if (need_to_work && spur_issue && cnt == 1) begin
        uart_work_done = 1'b1;
        result = 16'hDEAD;
      end
      if (need_to_work && resp_delay >= 0 && cnt == resp_delay + 2) uart_work_done = 1'b1;
    end
  end

  // Scoreboard consumer: every valid pulse pops one expected completion.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (if_valid || dm_valid) begin
        vcount++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected valid: if_valid=%b dm_valid=%b, expected no pulse", if_valid, dm_valid);
        end else begin
          e = sb.pop_front();
          check("sb kind (if_valid)", 16'(if_valid), 16'(e.fetch));
          check("sb data", e.fetch ? if_inst : dm_rdata, e.data);
          check("sb token", 16'(mem_act), 16'(e.act));
          check("sb timeout_err", 16'(timeout_err), 16'(e.terr));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b0;
    dm_rd = 1'b0;
    dm_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    act_model = '0;
    sb.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, " need_to_work"}, 16'(need_to_work), 16'd0);
    check({tag, " mem_rd"}, 16'(mem_rd), 16'd0);
    check({tag, " mem_wr"}, 16'(mem_wr), 16'd0);
    check({tag, " mem_addr"}, mem_addr, 16'd0);
    check({tag, " mem_value"}, mem_value, 16'd0);
    check({tag, " mem_act"}, 16'(mem_act), 16'd0);
    check({tag, " stall"}, 16'(stall), 16'd0);
    check({tag, " if_valid"}, 16'(if_valid), 16'd0);
    check({tag, " dm_valid"}, 16'(dm_valid), 16'd0);
    check({tag, " if_inst"}, if_inst, 16'd0);
    check({tag, " dm_rdata"}, dm_rdata, 16'd0);
    check({tag, " timeout_err"}, 16'(timeout_err), 16'd0);
  endtask

  task automatic wait_valid(output int lat, output bit got);
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      got = if_valid || dm_valid;
    end
    check("valid within bound", 16'(got), 16'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, explat, v0;
    bit ok, ntw, got, status;
    status = !v.fetch && v.rd && !v.wr && (v.addr == STAT);
    v0 = vcount;
    @(negedge clk);
    resp_delay  = v.delay;
    resp_result = v.res;
    front       = v.front;
    tail        = v.tail;
    if_addr     = v.addr;
    dm_addr     = v.addr;
    dm_wdata    = v.wdata;
    if_req      = v.fetch;
    dm_rd       = v.rd;
    dm_wr       = v.wr;
    if (!status) act_model = act_model + 2'd1;
    sb.push_back(sb_t'{v.fetch, v.exp_data, act_model, v.exp_terr});
    #1;
    ok  = (stall === 1'b1);
    ntw = 0;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      got = if_valid || dm_valid;
      if (need_to_work) begin
        ntw = 1;
        if (mem_addr !== v.addr || mem_wr !== v.wr || mem_rd !== !v.wr ||
            (v.wr && mem_value !== v.wdata)) ok = 0;
      end
      if (!got && stall !== 1'b1) ok = 0;
    end
    if_req = 1'b0;
    dm_rd  = 1'b0;
    dm_wr  = 1'b0;
    explat = status ? 1 : ((v.delay < 0) ? int'(TO) + 2 : v.delay + 3);
    check({tag, " valid seen"}, 16'(got), 16'd1);
    check({tag, " latency"}, 16'(lat), 16'(explat));
    check({tag, " stall in done"}, 16'(stall), 16'd0);
    check({tag, " cmd stable and stall held"}, 16'(ok), 16'd1);
    check({tag, " controller used"}, 16'(ntw), 16'(!status));
    @(negedge clk);
    @(negedge clk);
    check({tag, " pulse count"}, 16'(vcount - v0), 16'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global time limit: simulation still running, expected $finish");
    $fatal(1);
  end

  initial begin
    int lat, v0;
    bit got;
    vec_t fv;

    // fetch rd wr addr wdata front tail delay result exp_data exp_terr
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 4'd0, 4'd0,  2, 16'h4C01, 16'h4C01, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 16'h8000, 16'h0000, 4'd0, 4'd0,  0, 16'h1234, 16'h1234, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'hBF01, 16'h0000, 4'd3, 4'd5,  0, 16'h0000, 16'h0003, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 16'hBF00, 16'h0041, 4'd0, 4'd0,  3, 16'h7777, 16'h0003, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 16'hBF01, 16'h0000, 4'd7, 4'd7,  0, 16'h0000, 16'h0001, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 16'h0200, 16'hBEEF, 4'd0, 4'd0,  1, 16'h9999, 16'h0001, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 16'h0300, 16'h0000, 4'd0, 4'd0,  5, 16'hA5A5, 16'hA5A5, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 4'd0, 4'd0,  0, 16'h1111, 16'h1111, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 16'h0400, 16'h0000, 4'd0, 4'd0, -1, 16'hEEEE, 16'h0000, 1'b1};

    rst = 1'b1;
    if_req = 1'b0;
    if_addr = '0;
    dm_rd = 1'b0;
    dm_wr = 1'b0;
    dm_addr = '0;
    dm_wdata = '0;
    front = '0;
    tail = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset("reset");

    for (int i = 0; i < 9; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end
    check("timeout_err sticky", 16'(timeout_err), 16'd1);

    // Fetch and data in the same cycle: data is issued first, fetch next.
    do_reset();
    @(negedge clk);
    resp_delay  = 1;
    resp_result = 16'hD00D;
    if_addr = 16'h0030;
    dm_addr = 16'h8000;
    dm_wr   = 1'b0;
    if_req  = 1'b1;
    dm_rd   = 1'b1;
    act_model = act_model + 2'd1;
    sb.push_back(sb_t'{1'b0, 16'hD00D, act_model, 1'b0});
    act_model = act_model + 2'd1;
    sb.push_back(sb_t'{1'b1, 16'hF00F, act_model, 1'b0});
    wait_valid(lat, got);
    check("both: data completes first", 16'(dm_valid), 16'd1);
    check("both: first issued addr", mem_addr, 16'h8000);
    dm_rd = 1'b0;
    resp_result = 16'hF00F;
    wait_valid(lat, got);
    check("both: fetch completes second", 16'(if_valid), 16'd1);
    check("both: second issued addr", mem_addr, 16'h0030);
    if_req = 1'b0;

    // A done already high during ISSUE must not complete the op.
    spur_issue = 1;
    fv = '{1'b0, 1'b1, 1'b0, 16'h0500, 16'h0000, 4'd0, 4'd0, 2, 16'h2222, 16'h2222, 1'b0};
    run_vec(fv, "spurious");
    spur_issue = 0;

    // Reset while waiting abandons the op silently; tokens restart and wrap.
    @(negedge clk);
    resp_delay = -1;
    dm_addr = 16'h0600;
    dm_rd = 1'b1;
    repeat (3) @(negedge clk);
    check("abort: op in WAIT", 16'(need_to_work), 16'd1);
    v0 = vcount;
    do_reset();
    check_reset("abort");
    @(negedge clk);
    @(negedge clk);
    check("abort: no valid pulse", 16'(vcount - v0), 16'd0);
    for (int k = 0; k < 4; k++) begin
      fv = '{1'b1, 1'b0, 1'b0, 16'(16'h0100 + k), 16'h0000, 4'd0, 4'd0, 0,
             16'(16'h0111 * (k + 1)), 16'(16'h0111 * (k + 1)), 1'b0};
      run_vec(fv, $sformatf("wrap%0d", k));
    end
    check("token wrapped to 0", 16'(mem_act), 16'd0);
    check("scoreboard drained", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16'hFFFF: maximum WAIT cycles before an operation is abandoned.
REQ-002 Parameter UART_STAT_ADDR, default 16'hBF01: status address, served locally and never forwarded.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  instruction fetch request; if_addr  in  16  fetch address.
REQ-006 if_inst  out  16  fetched word; if_valid  out  1  one-cycle pulse, if_inst valid.
REQ-007 dm_rd, dm_wr  in  1 each  data request from MEM stage; dm_addr  in  16; dm_wdata  in  16.
REQ-008 dm_rdata  out  16  load result; dm_valid  out  1  one-cycle pulse on load or store completion.
REQ-009 stall  out  1  pipeline freeze, high while any accepted request is incomplete.
REQ-010 need_to_work, mem_rd, mem_wr  out  1 each; mem_addr  out  16; mem_value  out  16  command to the RAM/UART controller.
REQ-011 mem_act  out  2  operation token; uart_work_done  in  1  completion, valid only for the current token; result  in  16  controller read data.
REQ-012 front, tail  in  4 each  controller receive-queue pointers.
REQ-013 timeout_err  out  1  sticky error flag.

Function
REQ-014 States: IDLE, ISSUE, WAIT, DONE; encodings live in the package.
REQ-015 IDLE: dm_rd or dm_wr pending -> latch the data request; else if_req -> latch the fetch; else stay in IDLE. Data always beats fetch.
REQ-016 dm_rd and dm_wr both high is illegal: treat as write; the read is dropped.
REQ-017 dm_rd with dm_addr == UART_STAT_ADDR: no controller access; next cycle dm_rdata = {14'b0, front != tail, 1'b1}, dm_valid = 1, return to IDLE.
REQ-018 On entering ISSUE: mem_act <= mem_act + 1 (wraps 3 -> 0); need_to_work = 1; drive mem_rd, mem_wr, mem_addr, mem_value from the latch; go to WAIT.
REQ-019 mem_addr, mem_value, mem_rd, mem_wr, need_to_work stay stable from ISSUE until DONE.
REQ-020 WAIT: uart_work_done == 1 -> capture result, go to DONE. Otherwise increment the 16-bit wait counter.
REQ-021 Wait counter reaching TIMEOUT -> set timeout_err, return 16'h0000 as data, go to DONE.
REQ-022 DONE: need_to_work = 0. Pulse if_valid (fetch) or dm_valid (data) for exactly 1 cycle with the captured word. Clear the wait counter. Go to IDLE.
REQ-023 Minimum latency, accept to valid: 3 cycles (IDLE -> ISSUE -> WAIT with done present -> DONE).
REQ-024 stall = 1 combinationally in the accept cycle when a request is present, in ISSUE, and in WAIT; stall = 0 in DONE.
REQ-025 Requests arriving while busy are not latched. Requesters hold them until their valid pulse.
REQ-026 A uart_work_done that is already high in the ISSUE cycle is ignored; completion is sampled only in WAIT.
REQ-027 Store completion: dm_valid pulses and dm_rdata holds its previous value.

Reset
REQ-028 On rst: state = IDLE; mem_act = 2'b00; need_to_work, mem_rd, mem_wr = 0; mem_addr, mem_value = 0.
REQ-029 On rst: if_valid, dm_valid, stall = 0; if_inst, dm_rdata = 0; timeout_err = 0; wait counter = 0.
REQ-030 rst mid-operation abandons the operation with no valid pulse. The controller sees need_to_work drop; the next token differs from any it has echoed.

Structure
REQ-031 The shared defines header holds MemAddr, MemValue, ActBit, QueueSize widths, UartAddr, UART_STAT_ADDR and the state encodings.
REQ-032 The wait counter and timeout compare form one sub-module, op_watchdog (inputs clk, rst, run, clear; output expired).

Verification
REQ-033 Fetch if_addr=16'h0010 with controller answering result=16'h4C01 after 2 WAIT cycles -> if_inst=16'h4C01, if_valid pulses once, mem_act 0 -> 1.
REQ-034 if_req and dm_rd (addr 16'h8000) in the same cycle -> the data op is issued first; the fetch is issued next with mem_act advanced again.
REQ-035 dm_rd at 16'hBF01 with front=3, tail=5 -> dm_rdata=16'h0003 one cycle later; need_to_work never rises.
REQ-036 dm_wr addr 16'hBF00 data 16'h0041 -> mem_wr=1, mem_value=16'h0041 stable through WAIT; dm_valid pulses once on done.
REQ-037 TIMEOUT=8, controller never completes -> timeout_err=1 after 8 WAIT cycles; dm_rdata=0; stall drops.
REQ-038 rst asserted in WAIT -> all outputs take reset values the next cycle; four back-to-back ops afterwards wrap mem_act 3 -> 0.
